// File: rtl/clock_pkg.sv
// Shared clock types: mode encodings, field widths and limits.
// Used by time_keeper and the BCD converter stage.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

endpackage

// File: rtl/tick_gen.sv
// 1 Hz prescaler: counts 0..CLK_HZ-1 while enabled, else held at 0.
// Ports: clk, rst_n (async low), enable in; tick out (count==CLK_HZ-1).
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last;

  assign last = (cnt_q == LAST);
  assign tick = enable && last;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!enable || last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24h clock with RUN / SET_HOUR / SET_MIN setting via two pulse buttons.
// Ports: clk, rst_n, mode_btn, inc_btn in; hours, minutes, seconds, mode, sec_pulse out (all registered).
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_btn,
  input  logic              inc_btn,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [1:0]        mode,
  output logic              sec_pulse
);

  mode_e             mode_q;
  mode_e             mode_d;
  logic [HOUR_W-1:0] hours_q;
  logic [HOUR_W-1:0] hours_d;
  logic [MIN_W-1:0]  min_q;
  logic [MIN_W-1:0]  min_d;
  logic [SEC_W-1:0]  sec_q;
  logic [SEC_W-1:0]  sec_d;
  logic              pulse_q;
  logic              pulse_d;
  logic              tick;

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(mode_q == RUN),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= RUN;
      hours_q <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      hours_q <= hours_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_btn) begin
      unique case (mode_q)
        RUN:      mode_d = SET_HOUR;
        SET_HOUR: mode_d = SET_MIN;
        SET_MIN:  mode_d = RUN;
        default:  mode_d = RUN;
      endcase
    end else if (mode_q != RUN && mode_q != SET_HOUR && mode_q != SET_MIN) begin
      mode_d = RUN;
    end
  end

  always_comb begin
    hours_d = hours_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pulse_d = 1'b0;
    unique case (mode_q)
      RUN: begin
        if (tick) begin
          pulse_d = 1'b1;
          if (sec_q >= SEC_MAX) begin
            sec_d = '0;
            if (min_q >= MIN_MAX) begin
              min_d   = '0;
              hours_d = (hours_q >= HOUR_MAX) ? '0 : hours_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        // Leaving RUN clears seconds even if a tick lands on the same edge.
        if (mode_btn) begin
          sec_d = '0;
        end
      end
      SET_HOUR: begin
        if (!mode_btn && inc_btn) begin
          hours_d = (hours_q >= HOUR_MAX) ? '0 : hours_q + 5'd1;
        end
      end
      SET_MIN: begin
        if (!mode_btn && inc_btn) begin
          min_d = (min_q >= MIN_MAX) ? '0 : min_q + 6'd1;
        end
      end
      default: begin
        sec_d = '0;
      end
    endcase
  end

  assign hours     = hours_q;
  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign mode      = mode_q;
  assign sec_pulse = pulse_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper at CLK_HZ=4.
// Checks reset, counting, carries, set mode, collisions, async reset, range.
module tb_time_keeper;

  logic       clk;
  logic       rst_n;
  logic       mode_btn;
  logic       inc_btn;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       sec_pulse;

  int n_chk;
  int n_fail;

  time_keeper #(
    .CLK_HZ(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .mode     (mode),
    .sec_pulse(sec_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic m, input logic i);
    mode_btn = m;
    inc_btn  = i;
    @(posedge clk);
    #1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b0);
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".h"}, int'(hours), h);
    check({tag, ".m"}, int'(minutes), m);
    check({tag, ".s"}, int'(seconds), s);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;

    #2;
    check_time("rst", 0, 0, 0);
    check("rst.mode", int'(mode), 0);
    check("rst.pulse", int'(sec_pulse), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // basic counting: pulse on cycles 4, 8, 12
    for (int k = 1; k <= 12; k++) begin
      press(1'b0, 1'b0);
      check($sformatf("cnt.pulse%0d", k), int'(sec_pulse), (k % 4 == 0) ? 1 : 0);
      check($sformatf("cnt.sec%0d", k), int'(seconds), k / 4);
    end

    // set mode: hours 25 increments, minutes 61 increments
    press(1'b1, 1'b0);
    check("set.mode1", int'(mode), 1);
    check("set.sec_clr", int'(seconds), 0);
    for (int k = 1; k <= 25; k++) begin
      press(1'b0, 1'b1);
      check($sformatf("set.h%0d", k), int'(hours), k % 24);
    end
    press(1'b1, 1'b0);
    check("set.mode2", int'(mode), 2);
    for (int k = 1; k <= 61; k++) begin
      press(1'b0, 1'b1);
      check($sformatf("set.m%0d", k), int'(minutes), k % 60);
    end
    check_time("set.end", 1, 1, 0);

    // mode+inc collision in SET_HOUR
    press(1'b1, 1'b0);
    check("col.run", int'(mode), 0);
    press(1'b1, 1'b0);
    check("col.sethour", int'(mode), 1);
    press(1'b1, 1'b1);
    check("col.mode", int'(mode), 2);
    check("col.hours", int'(hours), 1);

    // inc in RUN ignored
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("runinc.mode", int'(mode), 0);
    check_time("runinc", 1, 1, 0);

    // reach SET_MIN at 10:20:00 then async reset
    press(1'b1, 1'b0);
    for (int k = 0; k < 9; k++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    for (int k = 0; k < 19; k++) press(1'b0, 1'b1);
    check_time("pre_rst", 10, 20, 0);
    check("pre_rst.mode", int'(mode), 2);
    #3;
    rst_n = 1'b0;
    #1;
    check_time("arst", 0, 0, 0);
    check("arst.mode", int'(mode), 0);
    check("arst.pulse", int'(sec_pulse), 0);
    rst_n = 1'b1;

    // full carry: set 23:59, run 58 s, then 23:59:59 -> 00:00:00
    press(1'b1, 1'b0);
    for (int k = 0; k < 23; k++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    for (int k = 0; k < 59; k++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check("carry.run", int'(mode), 0);
    idle(3);
    check("carry.nopulse", int'(sec_pulse), 0);
    check("carry.s0", int'(seconds), 0);
    idle(229);
    check_time("carry.58", 23, 59, 58);
    check("carry.pulse58", int'(sec_pulse), 1);
    idle(4);
    check_time("carry.59", 23, 59, 59);
    idle(3);
    check_time("carry.hold", 23, 59, 59);
    idle(1);
    check_time("carry.mid", 0, 0, 0);
    check("carry.pulse", int'(sec_pulse), 1);

    // tick and mode_btn on the same edge: clear wins
    idle(3);
    check("tm.pre", int'(sec_pulse), 0);
    press(1'b1, 1'b0);
    check("tm.mode", int'(mode), 1);
    check("tm.sec", int'(seconds), 0);
    check("tm.pulse", int'(sec_pulse), 1);

    // random button traffic, range invariant
    for (int k = 0; k < 20000; k++) begin
      press(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
      check("rand.range",
            int'(hours <= 5'd23 && minutes <= 6'd59 && seconds <= 6'd59 && mode <= 2'd2),
            1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
